// File: rtl/serdes_pkg.sv
// Shared definitions for the 4-bit serial link (tx and rx sides).
// State encodings, default geometry and the receiver sample offset.
package serdes_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_SLOT_CYCLES = 4;
  localparam int SAMPLE_OFS      = 1;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serializer_tx_if.sv
// Parallel word handshake into the serializer.
// Master drives the word, slave answers with ready.
interface serializer_tx_if #(
  parameter int DATA_W = serdes_pkg::DEF_DATA_W
) ();

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/ser_slot_timer.sv
// Slot and bit counters for one serial frame.
// Flags mark frame start, slot end, last cycle and the cycle before it.
module ser_slot_timer
  import serdes_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic frame_first_o,
  output logic slot_end_o,
  output logic frame_last_o,
  output logic pre_last_o
);

  localparam int SW = cnt_w(SLOT_CYCLES);
  localparam int BW = cnt_w(DATA_W);

  localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_PRE = SW'(SLOT_CYCLES - 2);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_W - 1);

  logic [SW-1:0] slot_q, slot_d;
  logic [BW-1:0] bit_q, bit_d;

  assign slot_end_o    = run_i && (slot_q == SLOT_MAX);
  assign frame_last_o  = slot_end_o && (bit_q == BIT_MAX);
  assign frame_first_o = run_i && (slot_q == '0) && (bit_q == '0);
  assign pre_last_o    = run_i && (slot_q == SLOT_PRE)
                         && (bit_q == BIT_MAX);

  // Advance slot, roll into bit; both reload to 0 at their ends.
  always_comb begin
    slot_d = slot_q;
    bit_d  = bit_q;
    if (run_i) begin
      if (slot_end_o) begin
        slot_d = '0;
        bit_d  = frame_last_o ? '0 : bit_q + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
      bit_q  <= '0;
    end else begin
      slot_q <= slot_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/serializer_tx.sv
// Framed MSB-first serializer with a one-word holding buffer.
// All line outputs are registered and computed one cycle ahead.
module serializer_tx
  import serdes_pkg::*;
#(
  parameter int   DATA_W      = DEF_DATA_W,
  parameter int   SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic            data_clk,
  input  logic            rst,
  serializer_tx_if.slave  tx,
  output logic            ser_data,
  output logic            frame_sync,
  output logic            frame_done,
  output logic            busy
);

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nx;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full_q;
  logic              ser_q;
  logic              sync_q;
  logic              done_q;

  logic frame_first;
  logic slot_end;
  logic frame_last;
  logic pre_last;
  logic xfer;

  ser_slot_timer #(
    .DATA_W      (DATA_W),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_timer (
    .clk_i         (data_clk),
    .rst_i         (rst),
    .run_i         (state_q == SHIFT),
    .frame_first_o (frame_first),
    .slot_end_o    (slot_end),
    .frame_last_o  (frame_last),
    .pre_last_o    (pre_last)
  );

  assign tx.din_ready = !buf_full_q && !rst;
  assign xfer         = tx.din_valid && tx.din_ready;
  assign shift_nx     = shift_q << 1;

  assign ser_data   = ser_q;
  assign frame_sync = sync_q;
  assign frame_done = done_q;
  assign busy       = (state_q == SHIFT) || buf_full_q;

  // Frame FSM: shift register, buffer and next-cycle line outputs.
  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      ser_q      <= IDLE_LEVEL;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync_q <= 1'b0;
      done_q <= pre_last;
      unique case (state_q)
        IDLE: begin
          ser_q <= IDLE_LEVEL;
          if (xfer) begin
            shift_q <= tx.din;
            ser_q   <= tx.din[DATA_W-1];
            sync_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (frame_last) begin
            if (buf_full_q) begin
              shift_q    <= buf_q;
              ser_q      <= buf_q[DATA_W-1];
              sync_q     <= 1'b1;
              buf_full_q <= 1'b0;
            end else if (xfer) begin
              shift_q <= tx.din;
              ser_q   <= tx.din[DATA_W-1];
              sync_q  <= 1'b1;
            end else begin
              shift_q <= '0;
              ser_q   <= IDLE_LEVEL;
              state_q <= IDLE;
            end
          end else begin
            if (xfer) begin
              buf_q      <= tx.din;
              buf_full_q <= 1'b1;
            end
            if (slot_end) begin
              shift_q <= shift_nx;
              ser_q   <= shift_nx[DATA_W-1];
            end
          end
        end
      endcase
    end
  end

  // Counters at zero inside a frame only ever coincide with the sync pulse.
  a_first_sync: assert property (
    @(posedge data_clk) disable iff (rst)
    frame_first |-> frame_sync
  );

endmodule

// File: tb/tb_serializer_tx.sv
// Self-checking bench for serializer_tx: vector table, corner sequences,
// random loopback through a frame_sync-restarted receiver model.
module tb_serializer_tx;
  import serdes_pkg::*;

  logic data_clk = 1'b0;
  logic rst;
  always #5 data_clk = ~data_clk;

  serializer_tx_if #(.DATA_W(4)) a_if ();
  serializer_tx_if #(.DATA_W(8)) b_if ();

  logic a_ser, a_sync, a_done, a_busy;
  logic b_ser, b_sync, b_done, b_busy;

  serializer_tx #(
    .DATA_W(4), .SLOT_CYCLES(4), .IDLE_LEVEL(1'b0)
  ) dut_a (
    .data_clk   (data_clk),
    .rst        (rst),
    .tx         (a_if),
    .ser_data   (a_ser),
    .frame_sync (a_sync),
    .frame_done (a_done),
    .busy       (a_busy)
  );

  serializer_tx #(
    .DATA_W(8), .SLOT_CYCLES(2), .IDLE_LEVEL(1'b0)
  ) dut_b (
    .data_clk   (data_clk),
    .rst        (rst),
    .tx         (b_if),
    .ser_data   (b_ser),
    .frame_sync (b_sync),
    .frame_done (b_done),
    .busy       (b_busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [3:0] d);
    a_if.din_valid = v;
    a_if.din       = d;
    @(posedge data_clk);
    @(negedge data_clk);
  endtask

  // Check A's outputs during frame cycle j of a two-frame run.
  task automatic chk_frame(input string nm, input int j,
                           input logic [3:0] w);
    chk({nm, " ser"},  a_ser,  w[3 - (j % 16) / 4]);
    chk({nm, " sync"}, a_sync, (j % 16) == 0);
    chk({nm, " done"}, a_done, (j % 16) == 15);
    chk({nm, " busy"}, a_busy, 1'b1);
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       ser;
    logic       sync;
    logic       done;
    logic       busy;
    logic       rdy;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] w;
    logic [7:0] wb;
    logic [3:0] q[$];
    logic [3:0] rx;
    logic [3:0] d;
    logic [3:0] expw;
    logic       v;
    int fc, sent, got, budget, bad;

    rst = 1'b1;
    a_if.din_valid = 1'b0;
    a_if.din       = '0;
    b_if.din_valid = 1'b0;
    b_if.din       = '0;
    repeat (2) @(posedge data_clk);
    @(negedge data_clk);
    chk("reset ser",   a_ser,  1'b0);
    chk("reset sync",  a_sync, 1'b0);
    chk("reset done",  a_done, 1'b0);
    chk("reset busy",  a_busy, 1'b0);
    chk("reset ready", a_if.din_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post-reset ready", a_if.din_ready, 1'b1);
    @(negedge data_clk);

    // Single 4'b1010 frame from idle, cycle by cycle.
    w = 4'b1010;
    tbl[0] = '{1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 16; k++)
      tbl[k+1] = '{1'b0, 4'h0, w[3 - k / 4], k == 0, k == 15,
                   1'b1, 1'b1};
    for (int k = 17; k < 20; k++)
      tbl[k] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("tbl[%0d] ser", i),  a_ser,  tbl[i].ser);
      chk($sformatf("tbl[%0d] sync", i), a_sync, tbl[i].sync);
      chk($sformatf("tbl[%0d] done", i), a_done, tbl[i].done);
      chk($sformatf("tbl[%0d] busy", i), a_busy, tbl[i].busy);
      chk($sformatf("tbl[%0d] rdy", i),  a_if.din_ready, tbl[i].rdy);
      cyc(tbl[i].v, tbl[i].d);
    end

    // Back-to-back: C then 3 buffered during frame 1.
    cyc(1'b1, 4'hC);
    for (int j = 0; j < 32; j++) begin
      chk_frame("b2b", j, (j < 16) ? 4'hC : 4'h3);
      chk($sformatf("b2b ready c%0d", j), a_if.din_ready,
          (j <= 3) || (j >= 16));
      cyc(j == 3, 4'h3);
    end
    chk("b2b end ser",  a_ser,  1'b0);
    chk("b2b end busy", a_busy, 1'b0);
    chk("b2b end done", a_done, 1'b0);

    // Transfer on the final edge of a frame bypasses the buffer.
    cyc(1'b1, 4'h9);
    for (int j = 0; j < 32; j++) begin
      chk_frame("bypass", j, (j < 16) ? 4'h9 : 4'h5);
      chk($sformatf("bypass ready c%0d", j), a_if.din_ready, 1'b1);
      cyc(j == 15, 4'h5);
    end
    chk("bypass end busy", a_busy, 1'b0);
    chk("bypass end ser",  a_ser,  1'b0);

    // Reset in frame cycle 7 with a word buffered.
    cyc(1'b1, 4'hF);
    for (int j = 0; j < 7; j++) cyc(j == 2, 4'h6);
    chk("pre-rst ser",   a_ser,  1'b1);
    chk("pre-rst busy",  a_busy, 1'b1);
    chk("pre-rst ready", a_if.din_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst ser",   a_ser,  1'b0);
    chk("rst busy",  a_busy, 1'b0);
    chk("rst sync",  a_sync, 1'b0);
    chk("rst done",  a_done, 1'b0);
    chk("rst ready", a_if.din_ready, 1'b0);
    bad = 0;
    repeat (3) begin
      @(negedge data_clk);
      if (a_done || a_ser || a_busy) bad++;
    end
    rst = 1'b0;
    for (int j = 0; j < 40; j++) begin
      cyc(1'b0, 4'h0);
      if (a_ser || a_busy || a_sync || a_done) bad++;
    end
    chk("post-rst quiet cycles", bad, 0);

    // DUT B: 8-bit word, 2-cycle slots.
    wb = 8'h81;
    b_if.din = wb;
    b_if.din_valid = 1'b1;
    @(posedge data_clk);
    @(negedge data_clk);
    b_if.din_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("w8 ser c%0d", k),  b_ser,  wb[7 - k / 2]);
      chk($sformatf("w8 sync c%0d", k), b_sync, k == 0);
      chk($sformatf("w8 done c%0d", k), b_done, k == 15);
      @(posedge data_clk);
      @(negedge data_clk);
    end
    chk("w8 end ser",  b_ser,  1'b0);
    chk("w8 end busy", b_busy, 1'b0);

    // Random loopback through a receiver model.
    sent = 0;
    got = 0;
    budget = 0;
    fc = 99;
    rx = '0;
    while ((sent < 200 || q.size() > 0 || a_busy) && budget < 20000) begin
      if (a_sync) fc = 0;
      else if (fc < 99) fc++;
      if (fc < 16 && (fc % 4) == SAMPLE_OFS) begin
        rx = {rx[2:0], a_ser};
        if (fc == 13) begin
          got++;
          if (q.size() == 0) begin
            chk("loopback extra word", 1, 0);
          end else begin
            expw = q.pop_front();
            chk($sformatf("loopback word %0d", got), rx, expw);
          end
        end
      end
      v = (sent < 200) && ($urandom_range(0, 3) != 0);
      d = 4'($urandom);
      if (v && a_if.din_ready) begin
        q.push_back(d);
        sent++;
      end
      cyc(v, d);
      budget++;
    end
    chk("loopback in budget", budget < 20000, 1);
    chk("loopback words recovered", got, 200);
    chk("loopback idle after", a_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
